alu_op_sequencer: RTL

- Initiator side of the ALU operand/result interface. Accepts one operation request over a valid/ready handshake and drives the ALU's opcode/A/B from held registers.
- Waits a configured number of cycles so the combinational ALU path (long for MUL/DIV) can settle, then captures the 64-bit Z into HI/LO result registers.
- Presents the result over a second valid/ready handshake.
- Sits between the control unit/datapath bus and the ALU, and replaces ad-hoc Y/Z register strobing.

---
 rtl/alu_op_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: holds one ALU request, waits for the ALU path to settle,
// captures Z into HI/LO and hands the result off over a valid/ready handshake.
module alu_op_sequencer #(
    parameter int ALU_CYCLES    = 1,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_opcode,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [4:0]  alu_opcode,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    input  logic [63:0] alu_Z,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] op_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    localparam logic [3:0] C_ALU = 4'(ALU_CYCLES - 1);
    localparam logic [3:0] C_MD  = 4'(MULDIV_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [4:0]  r_opcode;
    logic [31:0] r_a, r_b, r_hi, r_lo;
    logic        r_err;
    logic [15:0] r_count;
    logic        w_accept, w_capture, w_ack, w_legal, w_muldiv;

    function automatic logic is_legal(input logic [4:0] op);
        return (op >= 5'd3 && op <= 5'd11) || (op >= 5'd15 && op <= 5'd18);
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return op == 5'b01111 || op == 5'b10000;
    endfunction

    assign w_accept   = r_state == IDLE && req_valid;
    assign w_capture  = r_state == EXEC && r_cnt == 4'd0;
    assign w_ack      = r_state == DONE && rsp_ready;
    assign w_legal    = is_legal(r_opcode);
    assign w_muldiv   = is_muldiv(r_opcode);
    assign req_ready  = r_state == IDLE;
    assign rsp_valid  = r_state == DONE;
    assign busy       = r_state != IDLE;
    assign alu_opcode = r_opcode;
    assign alu_A      = r_a;
    assign alu_B      = r_b;
    assign rsp_hi     = r_hi;
    assign rsp_lo     = r_lo;
    assign rsp_err    = r_err;
    assign op_count   = r_count;

    // Illegal opcodes take one pass through EXEC with a zero count so their
    // response appears after the same single edge as a one-cycle op.
    always_comb begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                w_state_nxt = req_valid ? EXEC : IDLE;
                if (req_valid)
                    w_cnt_nxt = !is_legal(req_opcode) ? 4'd0 :
                                is_muldiv(req_opcode) ? C_MD : C_ALU;
            end
            EXEC: begin
                w_state_nxt = r_cnt == 4'd0 ? DONE : EXEC;
                w_cnt_nxt   = r_cnt == 4'd0 ? 4'd0 : r_cnt - 4'd1;
            end
            DONE:    w_state_nxt = rsp_ready ? IDLE : DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_opcode <= 5'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_err    <= 1'b0;
            r_count  <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_opcode <= req_opcode;
                r_a      <= req_a;
                r_b      <= req_b;
            end
            // The upper Z word is only meaningful for MUL/DIV.
            if (w_capture) begin
                r_err <= !w_legal;
                r_hi  <= (w_legal && w_muldiv) ? alu_Z[63:32] : 32'd0;
                r_lo  <= w_legal ? alu_Z[31:0] : 32'd0;
            end
            if (w_ack)
                r_count <= r_count + 16'd1;
        end
    end
endmodule
